// File: rtl/seg7_pkg.sv
// seg7_pkg -- shared constants and the nibble-to-glyph decode for the
// multiplexed 7-segment driver.
//   SUBSLOTS     brightness sub-slots per digit slot
//   GLYPH_*      active-high segment patterns, bit order {a,b,c,d,e,f,g,dp}
//   seg7_decode  nibble + hex_mode -> glyph (dp bit always 0)
package seg7_pkg;

  localparam int SUBSLOTS = 32'd16;

  localparam logic [7:0] GLYPH_0     = 8'hFC;
  localparam logic [7:0] GLYPH_1     = 8'h60;
  localparam logic [7:0] GLYPH_2     = 8'hDA;
  localparam logic [7:0] GLYPH_3     = 8'hF2;
  localparam logic [7:0] GLYPH_4     = 8'h66;
  localparam logic [7:0] GLYPH_5     = 8'hB6;
  localparam logic [7:0] GLYPH_6     = 8'hBE;
  localparam logic [7:0] GLYPH_7     = 8'hE0;
  localparam logic [7:0] GLYPH_8     = 8'hFE;
  localparam logic [7:0] GLYPH_9     = 8'hF6;
  localparam logic [7:0] GLYPH_A     = 8'hEE;
  localparam logic [7:0] GLYPH_B     = 8'h3E;
  localparam logic [7:0] GLYPH_C     = 8'h9C;
  localparam logic [7:0] GLYPH_D     = 8'h7A;
  localparam logic [7:0] GLYPH_E     = 8'h9E;
  localparam logic [7:0] GLYPH_F     = 8'h8E;
  localparam logic [7:0] GLYPH_BLANK = 8'h00;

  // Letters only exist in hex mode; an X/Z nibble falls through to blank.
  function automatic logic [7:0] seg7_decode(input logic [3:0] nibble,
                                             input logic       hex_mode);
    logic [7:0] g;
    case (nibble)
      4'h0:    g = GLYPH_0;
      4'h1:    g = GLYPH_1;
      4'h2:    g = GLYPH_2;
      4'h3:    g = GLYPH_3;
      4'h4:    g = GLYPH_4;
      4'h5:    g = GLYPH_5;
      4'h6:    g = GLYPH_6;
      4'h7:    g = GLYPH_7;
      4'h8:    g = GLYPH_8;
      4'h9:    g = GLYPH_9;
      4'hA:    g = hex_mode ? GLYPH_A : GLYPH_BLANK;
      4'hB:    g = hex_mode ? GLYPH_B : GLYPH_BLANK;
      4'hC:    g = hex_mode ? GLYPH_C : GLYPH_BLANK;
      4'hD:    g = hex_mode ? GLYPH_D : GLYPH_BLANK;
      4'hE:    g = hex_mode ? GLYPH_E : GLYPH_BLANK;
      4'hF:    g = hex_mode ? GLYPH_F : GLYPH_BLANK;
      default: g = GLYPH_BLANK;
    endcase
    return g;
  endfunction

endpackage

// File: rtl/seg7_mux_drv_if.sv
// seg7_mux_drv_if -- display-data bundle feeding the 7-segment driver.
//   data        4*NUM_DIGITS nibbles, nibble i -> digit i (digit 0 rightmost)
//   dp          per-digit decimal point
//   hex_mode    1: 0-F glyphs, 0: BCD (A-F blank)
//   lzb_en      leading-zero blanking enable
//   bright      0 (dark) .. 15 (15/16 duty)
//   blink_mask  digits that blink when built with SEG7_BLINK_EN
// Modports: master = display-data logic, slave = driver.
interface seg7_mux_drv_if #(
  parameter int NUM_DIGITS = 8
);
  logic [4*NUM_DIGITS-1:0] data;
  logic [NUM_DIGITS-1:0]   dp;
  logic                    hex_mode;
  logic                    lzb_en;
  logic [3:0]              bright;
  logic [NUM_DIGITS-1:0]   blink_mask;

  modport master (output data, dp, hex_mode, lzb_en, bright, blink_mask);
  modport slave  (input  data, dp, hex_mode, lzb_en, bright, blink_mask);
endinterface

// File: rtl/seg7_glyph_dec.sv
// seg7_glyph_dec -- combinational nibble + dp -> active-high segment pattern.
//   nibble    digit value
//   hex_mode  enables the A-F letters
//   blank     leading-zero blanked: a-g off, dp still shown
//   dp        decimal point for this digit
//   pattern   {a,b,c,d,e,f,g,dp}, active high (polarity handled by the top)
module seg7_glyph_dec
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       hex_mode,
  input  logic       blank,
  input  logic       dp,
  output logic [7:0] pattern
);

  logic [7:0] glyph_s;

  // Glyph lookup, then splice in the decimal point
  always_comb begin
    glyph_s = seg7_decode(nibble, hex_mode);
    pattern = GLYPH_BLANK;
    if (blank) begin
      pattern = {7'b000_0000, dp};
    end else begin
      pattern = {glyph_s[7:1], dp};
    end
  end

endmodule

// File: rtl/seg7_mux_drv.sv
// seg7_mux_drv -- N-digit multiplexed 7-segment driver with hex/BCD decode,
// leading-zero blanking, per-digit dp, 16-step brightness PWM and a dark
// guard sub-slot at the start of every digit slot. Single clock domain.
//   clk, rst_n   clock, async active-low reset
//   disp         seg7_mux_drv_if.slave display inputs (shadowed per frame)
//   seg          {a,b,c,d,e,f,g,dp} at SEG_ACTIVE_LOW polarity
//   dig          one-hot digit select at DIG_ACTIVE_LOW polarity
//   frame_start  one-cycle pulse on the first cycle of each frame
// Build option: define SEG7_BLINK_EN to add the blink frame counter and the
// blink_mask shadow; otherwise blink_mask is ignored.
module seg7_mux_drv
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS     = 8,
  parameter int DIGIT_CYCLES   = 5000,
  parameter int SEG_ACTIVE_LOW = 0,
  parameter int DIG_ACTIVE_LOW = 1,
  parameter int BLINK_FRAMES   = 128
) (
  input  logic                  clk,
  input  logic                  rst_n,
  seg7_mux_drv_if.slave         disp,
  output logic [7:0]            seg,
  output logic [NUM_DIGITS-1:0] dig,
  output logic                  frame_start
);

  localparam int SUB_LEN = DIGIT_CYCLES / SUBSLOTS;
  localparam int CW      = $clog2(DIGIT_CYCLES);
  localparam int DW      = $clog2(NUM_DIGITS);

  localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_CYCLES - 1);
  localparam logic [CW-1:0] SUB_LAST  = CW'(SUB_LEN - 1);
  localparam logic [DW-1:0] POS_LAST  = DW'(NUM_DIGITS - 1);

  // XOR masks: all-ones for active-low outputs, so "off" is the mask itself.
  localparam logic [7:0] SEG_OFF =
    (SEG_ACTIVE_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [NUM_DIGITS-1:0] DIG_OFF =
    (DIG_ACTIVE_LOW != 0) ? {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

  // Scan position. pos_r counts up from 0 while the digit index counts down
  // from NUM_DIGITS-1, so the all-zero reset state is the frame boundary.
  logic [CW-1:0] slot_cnt_r;
  logic [CW-1:0] sub_cnt_r;
  logic [3:0]    sub_idx_r;
  logic [DW-1:0] pos_r;

  // Per-frame shadows of the display inputs
  logic [4*NUM_DIGITS-1:0] data_sh_r;
  logic [NUM_DIGITS-1:0]   dp_sh_r;
  logic                    hex_sh_r;
  logic                    lzb_sh_r;
  logic [3:0]              bright_sh_r;

  logic [7:0]            seg_r;
  logic [NUM_DIGITS-1:0] dig_r;
  logic                  frame_start_r;

  logic                  boundary_s;
  logic                  frame_last_s;
  logic [DW-1:0]         dig_idx_s;
  logic [3:0]            cur_nib_s;
  logic                  cur_dp_s;
  logic                  cur_blank_s;
  logic [NUM_DIGITS-1:0] blank_s;
  logic                  zero_run_s;
  logic [7:0]            glyph_s;
  logic [NUM_DIGITS-1:0] dig_onehot_s;
  logic                  blink_dark_s;
  logic                  lit_s;

  assign boundary_s   = (pos_r == {DW{1'b0}}) && (slot_cnt_r == {CW{1'b0}});
  assign frame_last_s = (pos_r == POS_LAST) && (slot_cnt_r == SLOT_LAST);
  assign dig_idx_s    = POS_LAST - pos_r;
  assign cur_nib_s    = data_sh_r[{dig_idx_s, 2'b00} +: 4];
  assign cur_dp_s     = dp_sh_r[dig_idx_s];
  assign cur_blank_s  = blank_s[dig_idx_s];
  assign dig_onehot_s = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << dig_idx_s;

  // Slot / sub-slot / digit scan counters. The last sub-slot absorbs any
  // remainder when DIGIT_CYCLES is not an exact multiple of SUBSLOTS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_r <= {CW{1'b0}};
      sub_cnt_r  <= {CW{1'b0}};
      sub_idx_r  <= 4'd0;
      pos_r      <= {DW{1'b0}};
    end else if (slot_cnt_r == SLOT_LAST) begin
      slot_cnt_r <= {CW{1'b0}};
      sub_cnt_r  <= {CW{1'b0}};
      sub_idx_r  <= 4'd0;
      pos_r      <= (pos_r == POS_LAST) ? {DW{1'b0}} : pos_r + 1'b1;
    end else begin
      slot_cnt_r <= slot_cnt_r + 1'b1;
      if ((sub_cnt_r == SUB_LAST) && (sub_idx_r != 4'd15)) begin
        sub_cnt_r <= {CW{1'b0}};
        sub_idx_r <= sub_idx_r + 4'd1;
      end else begin
        sub_cnt_r <= sub_cnt_r + 1'b1;
      end
    end
  end

  // Input capture and strobe at the frame boundary
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_sh_r     <= {(4*NUM_DIGITS){1'b0}};
      dp_sh_r       <= {NUM_DIGITS{1'b0}};
      hex_sh_r      <= 1'b0;
      lzb_sh_r      <= 1'b0;
      bright_sh_r   <= 4'd0;
      frame_start_r <= 1'b0;
    end else begin
      frame_start_r <= boundary_s;
      if (boundary_s) begin
        data_sh_r   <= disp.data;
        dp_sh_r     <= disp.dp;
        hex_sh_r    <= disp.hex_mode;
        lzb_sh_r    <= disp.lzb_en;
        bright_sh_r <= disp.bright;
      end else begin
        data_sh_r   <= data_sh_r;
        dp_sh_r     <= dp_sh_r;
        hex_sh_r    <= hex_sh_r;
        lzb_sh_r    <= lzb_sh_r;
        bright_sh_r <= bright_sh_r;
      end
    end
  end

  // Leading-zero blanking: a digit blanks while every digit from the top
  // down to it is a zero nibble without dp. Digit 0 never blanks.
  always_comb begin
    blank_s    = {NUM_DIGITS{1'b0}};
    zero_run_s = lzb_sh_r;
    for (int i = NUM_DIGITS - 1; i >= 1; i--) begin
      zero_run_s = zero_run_s & (data_sh_r[4*i +: 4] == 4'h0) & ~dp_sh_r[i];
      blank_s[i] = zero_run_s;
    end
  end

  seg7_glyph_dec u_glyph (
    .nibble   (cur_nib_s),
    .hex_mode (hex_sh_r),
    .blank    (cur_blank_s),
    .dp       (cur_dp_s),
    .pattern  (glyph_s)
  );

`ifdef SEG7_BLINK_EN
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FW-1:0] FRAME_CNT_LAST = FW'(BLINK_FRAMES - 1);

  logic [NUM_DIGITS-1:0] blink_sh_r;
  logic [FW-1:0]         frame_cnt_r;
  logic                  blink_phase_r;

  // Blink phase flips after every BLINK_FRAMES completed frames
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_sh_r    <= {NUM_DIGITS{1'b0}};
      frame_cnt_r   <= {FW{1'b0}};
      blink_phase_r <= 1'b0;
    end else begin
      blink_sh_r <= boundary_s ? disp.blink_mask : blink_sh_r;
      if (frame_last_s && (frame_cnt_r == FRAME_CNT_LAST)) begin
        frame_cnt_r   <= {FW{1'b0}};
        blink_phase_r <= ~blink_phase_r;
      end else if (frame_last_s) begin
        frame_cnt_r   <= frame_cnt_r + 1'b1;
        blink_phase_r <= blink_phase_r;
      end else begin
        frame_cnt_r   <= frame_cnt_r;
        blink_phase_r <= blink_phase_r;
      end
    end
  end

  assign blink_dark_s = blink_phase_r & blink_sh_r[dig_idx_s];
`else
  logic unused_blink_s;
  assign unused_blink_s = ^{disp.blink_mask, frame_last_s, BLINK_FRAMES[0]};
  assign blink_dark_s   = 1'b0;
`endif

  // Sub-slot 0 is the ghost guard; sub-slots 1..bright are lit.
  assign lit_s = (sub_idx_r != 4'd0) && (sub_idx_r <= bright_sh_r) &&
                 !cur_blank_s && !blink_dark_s;

  // Pin registers: pattern and digit select update on the same edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_r <= SEG_OFF;
      dig_r <= DIG_OFF;
    end else if (lit_s) begin
      seg_r <= glyph_s ^ SEG_OFF;
      dig_r <= dig_onehot_s ^ DIG_OFF;
    end else begin
      seg_r <= SEG_OFF;
      dig_r <= DIG_OFF;
    end
  end

  assign seg         = seg_r;
  assign dig         = dig_r;
  assign frame_start = frame_start_r;

endmodule
